// File: rtl/iob_sync_assim_fifo.sv
// Single-clock FIFO with different write and read widths. Storage is kept in
// words of the narrower width, so each access moves WR or RR consecutive words.
module iob_sync_assim_fifo #(
    parameter int W_DATA_W = 16,
    parameter int R_DATA_W = 8,
    parameter int ADDR_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                w_en,
    input  logic [W_DATA_W-1:0] w_data,
    output logic                w_full,
    input  logic                r_en,
    output logic [R_DATA_W-1:0] r_data,
    output logic                r_empty,
    output logic [ADDR_W:0]     level,
    output logic                w_ovf,
    output logic                r_udf
);

    localparam int MIN   = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W;
    localparam int WR    = W_DATA_W / MIN;
    localparam int RR    = R_DATA_W / MIN;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [ADDR_W+1:0] DEPTH_X = (ADDR_W+2)'(DEPTH);
    localparam logic [ADDR_W+1:0] WR_X    = (ADDR_W+2)'(WR);
    localparam logic [ADDR_W+1:0] RR_X    = (ADDR_W+2)'(RR);
    localparam logic [ADDR_W:0]   WR_L    = (ADDR_W+1)'(WR);
    localparam logic [ADDR_W:0]   RR_L    = (ADDR_W+1)'(RR);
    localparam logic [ADDR_W-1:0] WR_P    = ADDR_W'(WR);
    localparam logic [ADDR_W-1:0] RR_P    = ADDR_W'(RR);

    logic [MIN-1:0] mem [DEPTH];

    logic [ADDR_W-1:0]            wptr;
    logic [ADDR_W-1:0]            rptr;
    logic                         wr_acc;
    logic                         rd_acc;
    logic [ADDR_W+1:0]            level_x;
    logic [WR-1:0][MIN-1:0]       w_slice;
    logic [WR-1:0][ADDR_W-1:0]    w_addr;
    logic [RR-1:0][ADDR_W-1:0]    r_addr;
    logic [RR-1:0][MIN-1:0]       r_word;
    logic [ADDR_W:0]              level_nxt;

    // Flags come straight from the current level, so a slot freed by a read
    // this cycle is not visible to a write until the next edge.
    assign level_x = {1'b0, level};
    assign w_full  = (DEPTH_X - level_x) < WR_X;
    assign r_empty = level_x < RR_X;
    assign wr_acc  = w_en & ~w_full;
    assign rd_acc  = r_en & ~r_empty;

    assign w_slice = w_data;

    // Slice addresses are ADDR_W wide so straddling accesses wrap for free.
    for (genvar k = 0; k < WR; k++) begin : g_wlane
        assign w_addr[k] = wptr + ADDR_W'(k);
    end

    for (genvar k = 0; k < RR; k++) begin : g_rlane
        assign r_addr[k] = rptr + ADDR_W'(k);
        assign r_word[k] = mem[r_addr[k]];
    end

    always_comb begin
        level_nxt = level;
        if (wr_acc) level_nxt = level_nxt + WR_L;
        if (rd_acc) level_nxt = level_nxt - RR_L;
    end

    // Storage is deliberately left out of reset; a reset only drops pointers.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int k = 0; k < WR; k++) begin
                mem[w_addr[k]] <= w_slice[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr   <= '0;
            rptr   <= '0;
            level  <= '0;
            r_data <= '0;
            w_ovf  <= 1'b0;
            r_udf  <= 1'b0;
        end else begin
            w_ovf <= w_en & w_full;
            r_udf <= r_en & r_empty;
            level <= level_nxt;
            if (wr_acc) wptr <= wptr + WR_P;
            if (rd_acc) begin
                rptr   <= rptr + RR_P;
                r_data <= r_word;
            end
        end
    end

endmodule

// File: tb/tb_iob_sync_assim_fifo.sv
// Bench for iob_sync_assim_fifo: byte-queue model checked every cycle on the
// 16->8 instance, plus directed literal checks on it and on an 8->32 instance.
module tb_iob_sync_assim_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        w_en, r_en;
    logic [15:0] w_data;
    logic        w_full, r_empty, w_ovf, r_udf;
    logic [7:0]  r_data;
    logic [4:0]  level;

    logic        w2_en, r2_en;
    logic [7:0]  w2_data;
    logic        w2_full, r2_empty, w2_ovf, r2_udf;
    logic [31:0] r2_data;
    logic [4:0]  level2;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    iob_sync_assim_fifo #(.W_DATA_W(16), .R_DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_data(w_data), .w_full(w_full),
        .r_en(r_en), .r_data(r_data), .r_empty(r_empty), .level(level),
        .w_ovf(w_ovf), .r_udf(r_udf)
    );

    iob_sync_assim_fifo #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .w_en(w2_en), .w_data(w2_data), .w_full(w2_full),
        .r_en(r2_en), .r_data(r2_data), .r_empty(r2_empty), .level(level2),
        .w_ovf(w2_ovf), .r_udf(r2_udf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the FIFO is a queue of bytes; a write appends two bytes
    // little-endian, a read pops one byte into the output register.
    byte unsigned q[$];
    logic [7:0]   m_rdata;
    logic         m_ovf, m_udf;

    initial begin
        m_rdata = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                m_rdata = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
            end else begin
                automatic bit full_pre  = (16 - q.size()) < 2;
                automatic bit empty_pre = q.size() < 1;
                m_ovf = w_en && full_pre;
                m_udf = r_en && empty_pre;
                if (r_en && !empty_pre) m_rdata = q.pop_front();
                if (w_en && !full_pre) begin
                    q.push_back(w_data[7:0]);
                    q.push_back(w_data[15:8]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("mdl_level",   32'(level),   32'(q.size()));
            chk("mdl_w_full",  32'(w_full),  32'((16 - q.size()) < 2));
            chk("mdl_r_empty", 32'(r_empty), 32'(q.size() < 1));
            chk("mdl_r_data",  32'(r_data),  32'(m_rdata));
            chk("mdl_w_ovf",   32'(w_ovf),   32'(m_ovf));
            chk("mdl_r_udf",   32'(r_udf),   32'(m_udf));
        end
    end

    task automatic step(input logic we, input logic [15:0] wd, input logic re);
        w_en = we; w_data = wd; r_en = re;
        @(negedge clk);
        w_en = 1'b0; r_en = 1'b0;
    endtask

    task automatic step2(input logic we, input logic [7:0] wd, input logic re);
        w2_en = we; w2_data = wd; r2_en = re;
        @(negedge clk);
        w2_en = 1'b0; r2_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        w_en = 1'b0; r_en = 1'b0; w_data = '0;
        w2_en = 1'b0; r2_en = 1'b0; w2_data = '0;
        @(negedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        chk("rst_level",   32'(level),   32'd0);
        chk("rst_r_empty", 32'(r_empty), 32'd1);
        chk("rst_w_full",  32'(w_full),  32'd0);
        chk("rst_r_data",  32'(r_data),  32'h00);

        // Underflow on empty
        step(1'b0, 16'h0, 1'b1);
        chk("udf_pulse", 32'(r_udf),  32'd1);
        chk("udf_rdata", 32'(r_data), 32'h00);
        chk("udf_level", 32'(level),  32'd0);
        step(1'b0, 16'h0, 1'b0);
        chk("udf_clear", 32'(r_udf), 32'd0);

        // Basic width conversion
        step(1'b1, 16'hBBAA, 1'b0);
        chk("b_level2", 32'(level), 32'd2);
        step(1'b0, 16'h0, 1'b1);
        chk("b_rd0", 32'(r_data), 32'hAA);
        chk("b_level1", 32'(level), 32'd1);
        step(1'b0, 16'h0, 1'b1);
        chk("b_rd1", 32'(r_data), 32'hBB);
        chk("b_level0", 32'(level), 32'd0);
        chk("b_empty", 32'(r_empty), 32'd1);

        // Fill, overflow, drain
        for (int i = 0; i < 8; i++) begin
            step(1'b1, {8'(i + 1), 8'(i)}, 1'b0);
        end
        chk("f_level16", 32'(level), 32'd16);
        chk("f_full",    32'(w_full), 32'd1);
        step(1'b1, 16'hFFFF, 1'b0);
        chk("f_ovf",     32'(w_ovf), 32'd1);
        chk("f_level_hold", 32'(level), 32'd16);
        step(1'b0, 16'h0, 1'b0);
        chk("f_ovf_clear", 32'(w_ovf), 32'd0);
        for (int j = 0; j < 16; j++) begin
            step(1'b0, 16'h0, 1'b1);
            chk("f_drain", 32'(r_data), 32'((j / 2) + (j % 2)));
        end
        chk("f_empty_end", 32'(r_empty), 32'd1);

        // Simultaneous read and write at level 4, then mixed traffic over wrap
        step(1'b1, 16'h4433, 1'b0);
        step(1'b1, 16'h6655, 1'b0);
        chk("s_level4", 32'(level), 32'd4);
        step(1'b1, 16'h2211, 1'b1);
        chk("s_level5", 32'(level), 32'd5);
        chk("s_oldest", 32'(r_data), 32'h33);
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        repeat (20) step(1'b0, 16'h0, 1'b1);
        chk("s_drained", 32'(level), 32'd0);

        // Narrow-write, wide-read instance
        step2(1'b1, 8'h11, 1'b0);
        step2(1'b1, 8'h22, 1'b0);
        step2(1'b1, 8'h33, 1'b0);
        chk("w32_empty3", 32'(r2_empty), 32'd1);
        chk("w32_level3", 32'(level2),   32'd3);
        step2(1'b0, 8'h0, 1'b1);
        chk("w32_udf", 32'(r2_udf), 32'd1);
        chk("w32_hold", r2_data, 32'h0);
        step2(1'b1, 8'h44, 1'b0);
        chk("w32_empty4", 32'(r2_empty), 32'd0);
        step2(1'b0, 8'h0, 1'b1);
        chk("w32_rdata", r2_data, 32'h44332211);
        chk("w32_level0", 32'(level2), 32'd0);

        // Mid-stream asynchronous reset at level 6
        step(1'b1, 16'h5A3C, 1'b0);
        step(1'b1, 16'h1111, 1'b0);
        step(1'b1, 16'h2222, 1'b0);
        step(1'b1, 16'h3333, 1'b0);
        step(1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        chk("r_level6", 32'(level), 32'd6);
        chk("r_pre_rdata", 32'(r_data), 32'h5A);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_level",   32'(level),   32'd0);
        chk("ar_r_data",  32'(r_data),  32'h00);
        chk("ar_r_empty", 32'(r_empty), 32'd1);
        chk("ar_w_full",  32'(w_full),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 16'hBBAA, 1'b0);
        step(1'b0, 16'h0, 1'b1);
        chk("ar_after", 32'(r_data), 32'hAA);
        chk("ar_level_after", 32'(level), 32'd1);

        step(1'b0, 16'h0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
